// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM state encoding and default bus widths.
// Latency: none, declarations only.
// Backpressure: not applicable.
package apb_pkg;

    // Default geometry, shared with APB responders on the same bus
    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    // Bridge transfer phases
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; flags expiry once TIMEOUT_CYCLES waits have been counted.
// Latency: count updates one cycle after i_en; o_expired is combinational from the count.
// Backpressure: none; TIMEOUT_CYCLES = 0 keeps o_expired low forever.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    // A zero limit still needs a one-bit counter so the logic stays well formed
    localparam int              CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    // Count enabled cycles, holding at the limit instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && (r_count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Converts valid/ready commands into single APB3 transfers and returns status on a response channel.
// Latency: accept -> SETUP -> ACCESS (+1 per PREADY wait) -> response; 4 cycles per zero-wait transfer.
// Backpressure: one transfer in flight; oCMD_READY stays low until the response is consumed.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  iPCLK,
    input  logic                  iPRESETn,
    input  logic                  iCMD_VALID,
    output logic                  oCMD_READY,
    input  logic                  iCMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] iCMD_ADDR,
    input  logic [DATA_WIDTH-1:0] iCMD_WDATA,
    output logic                  oRSP_VALID,
    input  logic                  iRSP_READY,
    output logic [DATA_WIDTH-1:0] oRSP_RDATA,
    output logic                  oRSP_ERR,
    output logic                  oRSP_TIMEOUT,
    output logic                  oPSEL,
    output logic                  oPENABLE,
    output logic                  oPWRITE,
    output logic [ADDR_WIDTH-1:0] oPADDR,
    output logic [DATA_WIDTH-1:0] oPWDATA,
    input  logic [DATA_WIDTH-1:0] iPRDATA,
    input  logic                  iPREADY,
    input  logic                  iPSLVERR
);

    apb_state_t            r_state;
    logic                  r_cmd_ready;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_tmr_clr;
    logic                  w_tmr_en;
    logic                  w_tmr_expired;

    // Counter is zeroed in SETUP and counts ACCESS cycles that see PREADY low.
    // Expiry is only acted on in a cycle where PREADY is still low, so a slave
    // completing on the limit cycle is treated as a normal completion.
    assign w_tmr_clr = (r_state == ST_SETUP);
    assign w_tmr_en  = (r_state == ST_ACCESS) && !iPREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clk     (iPCLK),
        .i_rst_n   (iPRESETn),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Transfer sequencer; every output is a register so APB controls are glitch free
    always_ff @(posedge iPCLK or negedge iPRESETn) begin
        if (!iPRESETn) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_vld     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cmd_ready && iCMD_VALID) begin
                        r_pwrite    <= iCMD_WRITE;
                        r_paddr     <= iCMD_ADDR;
                        r_pwdata    <= iCMD_WDATA;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (iPREADY) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : iPRDATA;
                        r_rsp_err     <= iPSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_vld     <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (w_tmr_expired) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_vld     <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (iRSP_READY) begin
                        r_rsp_vld   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oCMD_READY   = r_cmd_ready;
    assign oPSEL        = r_psel;
    assign oPENABLE     = r_penable;
    assign oPWRITE      = r_pwrite;
    assign oPADDR       = r_paddr;
    assign oPWDATA      = r_pwdata;
    assign oRSP_VALID   = r_rsp_vld;
    assign oRSP_RDATA   = r_rsp_rdata;
    assign oRSP_ERR     = r_rsp_err;
    assign oRSP_TIMEOUT = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed cases then randomized transfers against a transaction-level model.
// Latency: bench acts as APB slave with a programmable number of PREADY wait cycles.
// Backpressure: response consumer stalls for a random number of cycles.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iCMD_VALID;
    logic          oCMD_READY;
    logic          iCMD_WRITE;
    logic [AW-1:0] iCMD_ADDR;
    logic [DW-1:0] iCMD_WDATA;
    logic          oRSP_VALID;
    logic          iRSP_READY;
    logic [DW-1:0] oRSP_RDATA;
    logic          oRSP_ERR;
    logic          oRSP_TIMEOUT;
    logic          oPSEL;
    logic          oPENABLE;
    logic          oPWRITE;
    logic [AW-1:0] oPADDR;
    logic [DW-1:0] oPWDATA;
    logic [DW-1:0] iPRDATA;
    logic          iPREADY;
    logic          iPSLVERR;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iPCLK        (clk),
        .iPRESETn     (rst_n),
        .iCMD_VALID   (iCMD_VALID),
        .oCMD_READY   (oCMD_READY),
        .iCMD_WRITE   (iCMD_WRITE),
        .iCMD_ADDR    (iCMD_ADDR),
        .iCMD_WDATA   (iCMD_WDATA),
        .oRSP_VALID   (oRSP_VALID),
        .iRSP_READY   (iRSP_READY),
        .oRSP_RDATA   (oRSP_RDATA),
        .oRSP_ERR     (oRSP_ERR),
        .oRSP_TIMEOUT (oRSP_TIMEOUT),
        .oPSEL        (oPSEL),
        .oPENABLE     (oPENABLE),
        .oPWRITE      (oPWRITE),
        .oPADDR       (oPADDR),
        .oPWDATA      (oPWDATA),
        .iPRDATA      (iPRDATA),
        .iPREADY      (iPREADY),
        .iPSLVERR     (iPSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One complete transfer; called at a negedge with the bridge idle or about to be.
    // Model: the slave holds PREADY low for 'waits' ACCESS cycles. The transfer
    // aborts once more than TO waits would be needed, after TO+1 ACCESS cycles.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input logic slverr, input logic [DW-1:0] prdata,
                           input int hold);
        int            n;
        int            acc;
        logic          done;
        logic          exp_to;
        int            exp_acc;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;

        exp_to    = (waits > TO);
        exp_acc   = exp_to ? TO + 1 : waits + 1;
        exp_rdata = (exp_to || wr) ? '0 : prdata;
        exp_err   = exp_to ? 1'b1 : slverr;

        iCMD_VALID = 1'b1;
        iCMD_WRITE = wr;
        iCMD_ADDR  = addr;
        iCMD_WDATA = wdata;
        iPREADY    = 1'b0;
        n = 0;
        while (!oCMD_READY && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_accept", oCMD_READY, 1);

        // SETUP cycle; scramble the command bus to prove the bridge latched it
        @(negedge clk);
        iCMD_VALID = 1'b0;
        iCMD_WRITE = ~wr;
        iCMD_ADDR  = $urandom;
        iCMD_WDATA = $urandom;
        chk("setup_psel_penable", {oPSEL, oPENABLE}, 2'b10);
        chk("setup_cmd_ready", oCMD_READY, 0);
        chk("setup_paddr", oPADDR, addr);
        chk("setup_pwrite", oPWRITE, wr);
        chk("setup_pwdata", oPWDATA, wdata);

        acc  = 0;
        done = 1'b0;
        while (!done && acc < 40) begin
            @(negedge clk);
            if (oRSP_VALID) begin
                done = 1'b1;
            end else begin
                acc++;
                chk("access_psel_penable", {oPSEL, oPENABLE}, 2'b11);
                chk("access_paddr", oPADDR, addr);
                chk("access_pwdata", oPWDATA, wdata);
                if (acc > waits) begin
                    iPREADY  = 1'b1;
                    iPSLVERR = slverr;
                    iPRDATA  = prdata;
                end else begin
                    iPREADY  = 1'b0;
                    iPSLVERR = 1'($urandom);
                    iPRDATA  = $urandom;
                end
            end
        end
        iPREADY  = 1'b0;
        iPSLVERR = 1'b0;
        chk("rsp_valid_seen", oRSP_VALID, 1);
        chk("access_cycles", acc, exp_acc);
        chk("rsp_rdata", oRSP_RDATA, exp_rdata);
        chk("rsp_err", oRSP_ERR, exp_err);
        chk("rsp_timeout", oRSP_TIMEOUT, exp_to);
        chk("resp_psel_penable", {oPSEL, oPENABLE}, 2'b00);
        chk("resp_cmd_ready", oCMD_READY, 0);

        // Consumer stalls while a competing command is offered
        for (int i = 0; i < hold; i++) begin
            iCMD_VALID = 1'b1;
            iCMD_ADDR  = $urandom;
            @(negedge clk);
            chk("hold_rsp_valid", oRSP_VALID, 1);
            chk("hold_cmd_ready", oCMD_READY, 0);
            chk("hold_rdata", oRSP_RDATA, exp_rdata);
            chk("hold_err_timeout", {oRSP_ERR, oRSP_TIMEOUT}, {exp_err, exp_to});
            chk("hold_psel", oPSEL, 0);
        end
        iCMD_VALID = 1'b0;
        iRSP_READY = 1'b1;
        @(negedge clk);
        iRSP_READY = 1'b0;
        chk("post_rsp_cmd_ready", oCMD_READY, 1);
        chk("post_rsp_valid", oRSP_VALID, 0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        iCMD_VALID = 1'b0;
        iCMD_WRITE = 1'b0;
        iCMD_ADDR  = '0;
        iCMD_WDATA = '0;
        iRSP_READY = 1'b0;
        iPRDATA    = '0;
        iPREADY    = 1'b0;
        iPSLVERR   = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {oCMD_READY, oRSP_VALID, oPSEL, oPENABLE, oPWRITE, oRSP_ERR, oRSP_TIMEOUT}, 7'd0);
        chk("reset_paddr", oPADDR, 0);
        chk("reset_pwdata", oPWDATA, 0);
        chk("reset_rdata", oRSP_RDATA, 0);
        rst_n = 1'b1;
        chk("cmd_ready_before_edge", oCMD_READY, 0);
        @(negedge clk);
        chk("cmd_ready_after_release", oCMD_READY, 1);

        // Directed cases
        run_txn(1'b1, 32'h4, 32'hA5A5_0001, 0, 1'b0, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 32'h0, 32'h0, 3, 1'b0, 32'h0000_00F0, 0);
        run_txn(1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h1234_5678, 1);
        run_txn(1'b0, 32'h20, 32'h0, 6, 1'b0, 32'h5555_AAAA, 0);
        run_txn(1'b1, 32'h24, 32'h0BAD_F00D, TO, 1'b1, 32'h0, 0);
        run_txn(1'b0, 32'h28, 32'h0, TO, 1'b0, 32'hCAFE_0001, 2);
        run_txn(1'b1, 32'h8, 32'h7777_0000, 2, 1'b0, 32'h0, 5);

        // Reset pulsed during ACCESS
        iCMD_VALID = 1'b1;
        iCMD_WRITE = 1'b0;
        iCMD_ADDR  = 32'h30;
        iPREADY    = 1'b0;
        n = 0;
        while (!oCMD_READY && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        iCMD_VALID = 1'b0;
        @(negedge clk);
        chk("rst_pre_access", {oPSEL, oPENABLE}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_psel_penable", {oPSEL, oPENABLE}, 2'b00);
        chk("rst_async_rsp_valid", oRSP_VALID, 0);
        @(negedge clk);
        chk("rst_held_rsp_valid", oRSP_VALID, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_cmd_ready", oCMD_READY, 1);
        chk("rst_release_rsp_valid", oRSP_VALID, 0);
        run_txn(1'b0, 32'h34, 32'h0, 0, 1'b0, 32'h0BEE_F00D, 0);

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), $urandom, $urandom, $urandom_range(0, 7),
                    1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
